fp9_addsub_ctrl: RTL

Sequential issue/capture controller that sits directly upstream and downstream of the combinational 9-bit float add/sub datapath. The datapath format is {sign, 4-bit exp, 4-bit fract} with a hidden leading 1.
- Accepts operand pairs over a valid/ready handshake and registers them.
- Drives them, held stable, into the datapath.
- Waits a programmable settle time, then captures sum/overflow/zero.
- Applies exception clean-up and presents the result over a valid/ready output handshake.

---
 rtl/fp9_addsub_ctrl_if.sv | 25 ++
 rtl/fp9_addsub_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/fp9_addsub_ctrl_if.sv
// Operand-in / result-out handshake bundle for the fp9 add/sub controller.
interface fp9_addsub_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_a;
    logic [8:0] in_b;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_result;
    logic       out_overflow;
    logic       out_zero;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_zero
    );

    // Controller side.
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_zero
    );
endinterface

// File: rtl/fp9_addsub_ctrl.sv
// Issue/capture controller around a combinational 9-bit float add/sub
// datapath: registers operands, holds them for a settle time, captures the
// datapath result with exception clean-up and presents it downstream.
module fp9_addsub_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int SAT_ON_OVF    = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk50M,
    input  logic             rst,
    fp9_addsub_ctrl_if.slave bus,
    output logic [8:0]       add_a,
    output logic [8:0]       add_b,
    output logic             add_cin,
    input  logic [8:0]       add_sum,
    input  logic             add_overflow,
    input  logic             add_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       accept;

    // Exact cancellation wins over overflow; overflow optionally saturates
    // the magnitude while keeping the datapath sign.
    function automatic logic [8:0] clean_result(input logic [8:0] sum,
                                                input logic       ovf,
                                                input logic       zero);
        if (zero)
            return 9'h000;
        else if (ovf && (SAT_ON_OVF != 0))
            return {sum[8], 8'hFF};
        else
            return sum;
    endfunction

    // A new pair can enter when idle, or when the held result leaves this cycle.
    assign bus.in_ready = (state == IDLE) | ((state == HOLD) & bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign busy         = (state != IDLE);

    // Control FSM with registered datapath drive and result capture.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            state            <= IDLE;
            settle_cnt       <= 4'd0;
            add_a            <= 9'h000;
            add_b            <= 9'h000;
            add_cin          <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_result   <= 9'h000;
            bus.out_overflow <= 1'b0;
            bus.out_zero     <= 1'b0;
            op_count         <= '0;
        end else begin
            if (accept) begin
                add_a      <= bus.in_a;
                add_b      <= bus.in_b;
                add_cin    <= bus.in_sub;
                settle_cnt <= SETTLE_LOAD;
            end
            case (state)
                IDLE: begin
                    if (accept)
                        state <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        bus.out_result   <= clean_result(add_sum, add_overflow, add_zero);
                        bus.out_overflow <= add_overflow;
                        bus.out_zero     <= add_zero;
                        bus.out_valid    <= 1'b1;
                        state            <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        op_count      <= op_count + 1'b1;
                        bus.out_valid <= 1'b0;
                        state         <= accept ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
